// File: rtl/pipe_reg.sv
// Elastic valid/ready register pipeline with collapsing bubbles and synchronous flush.
// Optional feature: define PIPE_REG_OCC_EN to add the registered occupancy counter and port.
module pipe_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0]            ready;
    logic                        hole;

    // A stage can take new data if any stage at or after it is empty, or the tail drains.
    always_comb begin
        ready = '0;
        hole  = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hole     = hole | ~valid_q[i];
            ready[i] = hole;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (ready[0]) begin
                valid_d[0] = in_valid;
                if (in_valid) begin
                    data_d[0] = in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ready[i]) begin
                    valid_d[i] = valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // reset gates in_ready directly so nothing is offered as accepted while held in reset
    assign in_ready  = ready[0] & ~flush & reset;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        occ_d    = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: queue-of-entries reference model plus directed scenarios.
module tb_pipe_reg;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_OCC_EN
    logic [2:0]       occupancy;
`endif

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_REG_OCC_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: ordered entries, each with its stage position; entries advance one stage
    // per cycle unless blocked by the entry ahead; the head leaves from the last stage.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               pos;
    } ent_t;
    ent_t q[$];

    function automatic bit step_model(input bit commit);
        int   lim;
        int   np[$];
        bit   pop;
        bit   rdy;
        int   s;
        ent_t e;
        lim = DEPTH - 1;
        pop = (q.size() > 0) && (q[0].pos == DEPTH - 1) && (out_ready === 1'b1) && (flush !== 1'b1);
        s   = pop ? 1 : 0;
        for (int k = s; k < q.size(); k++) begin
            int p;
            p = q[k].pos + 1;
            if (p > lim) p = lim;
            np.push_back(p);
            lim = p - 1;
        end
        rdy = (reset === 1'b1) && (flush !== 1'b1) && !((np.size() > 0) && (np[np.size()-1] == 0));
        if (commit) begin
            if (flush === 1'b1) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                for (int k = 0; k < q.size(); k++) q[k].pos = np[k];
                if ((in_valid === 1'b1) && rdy) begin
                    e.d   = in_data;
                    e.pos = 0;
                    q.push_back(e);
                end
            end
        end
        return rdy;
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1) void'(step_model(1'b1));
    end

    always @(negedge clk) begin
        bit er;
        bit eov;
        er  = step_model(1'b0);
        eov = (reset === 1'b1) && (flush !== 1'b1) && (q.size() > 0) && (q[0].pos == DEPTH - 1);
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, eov);
        if (eov) chk("out_data", out_data, q[0].d);
        if (reset !== 1'b1) chk("rst_out_data", out_data, 0);
`ifdef PIPE_REG_OCC_EN
        chk("occupancy", occupancy, q.size());
`endif
    end

    logic [WIDTH-1:0] log_d[$];
    int               log_c[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            log_d.push_back(out_data);
            log_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_c.delete();
    endtask

    logic [2:0] vec [20] = '{3'b110, 3'b100, 3'b100, 3'b101, 3'b110, 3'b100, 3'b100,
                             3'b100, 3'b100, 3'b100, 3'b111, 3'b110, 3'b010, 3'b110,
                             3'b100, 3'b110, 3'b010, 3'b000, 3'b110, 3'b110};

    initial begin
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_data", out_data, 0);
        #10 reset = 1'b1;
        tick();

        // back-to-back stream 1..8
        clear_log();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k);
            tick();
            if (k == 1) acc = cyc;
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("t1_count", log_d.size(), 8);
        for (int j = 0; j < 8 && j < log_d.size(); j++) begin
            chk("t1_data", log_d[j], j + 1);
            chk("t1_cycle", log_c[j], acc + 3 + j);
        end

        // fill with stalled output, then drain
        clear_log();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0011 + WIDTH'(k);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 16'h0011);
`ifdef PIPE_REG_OCC_EN
        chk("t2_occupancy", occupancy, 4);
`endif
        repeat (2) tick();
        chk("t2_out_data_stable", out_data, 16'h0011);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t2_empty", out_valid, 0);
        chk("t2_count", log_d.size(), 4);
        for (int j = 0; j < 4 && j < log_d.size(); j++) begin
            chk("t2_data", log_d[j], 16'h0011 + j);
            chk("t2_cycle", log_c[j], log_c[0] + j);
        end

        // full pipe: accept and emit on the same edge
        clear_log();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0021 + WIDTH'(k);
            tick();
        end
        in_data   = 16'hA5A5;
        out_ready = 1'b1;
        #1;
        chk("t3_in_ready", in_ready, 1);
        chk("t3_out_data", out_data, 16'h0021);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3_out_data_next", out_data, 16'h0022);
`ifdef PIPE_REG_OCC_EN
        chk("t3_occupancy", occupancy, 4);
`endif
        repeat (6) tick();
        chk("t3_count", log_d.size(), 5);
        if (log_d.size() == 5) begin
            chk("t3_first", log_d[0], 16'h0021);
            chk("t3_last", log_d[4], 16'hA5A5);
        end

        // flush with three entries in flight and a concurrent input
        clear_log();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0031 + WIDTH'(k);
            tick();
        end
        flush   = 1'b1;
        in_data = 16'h0099;
        #1;
        chk("t4_in_ready_flush", in_ready, 0);
        chk("t4_out_valid_flush", out_valid, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t4_out_valid_after", out_valid, 0);
`ifdef PIPE_REG_OCC_EN
        chk("t4_occupancy", occupancy, 0);
`endif
        repeat (6) tick();
        chk("t4_no_output", log_d.size(), 0);

        // flush while the tail entry is presented
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0051 + WIDTH'(k);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t5_out_valid", out_valid, 1);
        chk("t5_out_data", out_data, 16'h0051);
        flush = 1'b1;
        #1;
        chk("t5_out_valid_forced", out_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_out_valid_after", out_valid, 0);
        chk("t5_data_untouched", out_data, 16'h0051);
        clear_log();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t5_no_output", log_d.size(), 0);

        // asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0041 + WIDTH'(k);
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        q.delete();
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_in_ready", in_ready, 0);
`ifdef PIPE_REG_OCC_EN
        chk("t6_occupancy", occupancy, 0);
`endif
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        #1;
        chk("t6_in_ready_release", in_ready, 1);
        clear_log();
        tick();
        acc      = cyc;
        in_valid = 1'b0;
        repeat (6) tick();
        chk("t6_count", log_d.size(), 1);
        if (log_d.size() == 1) begin
            chk("t6_data", log_d[0], 16'h1234);
            chk("t6_cycle", log_c[0], acc + 3);
        end

        // mixed directed vectors: {in_valid, out_ready, flush}
        for (int i = 0; i < 20; i++) begin
            in_valid  = vec[i][2];
            out_ready = vec[i][1];
            flush     = vec[i][0];
            in_data   = 16'h7000 + WIDTH'(i);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        chk("t7_drained", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 flush  input  1  synchronous discard of all in-flight entries.
REQ-006 in_valid  input  1  upstream has data on in_data.
REQ-007 in_ready  output  1  pipe accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  payload of the last stage.
REQ-012 occupancy  output  $clog2(DEPTH+1)  number of valid stages; present only with PIPE_REG_OCC_EN.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold one valid bit and one WIDTH-bit data register; stage 0 faces input, stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage ready: ready[DEPTH-1] = ~valid[DEPTH-1] | out_ready; ready[i] = ~valid[i] | ready[i+1]; combinational, bubbles collapse.
REQ-015 in_ready SHALL equal ready[0] & ~flush.
REQ-016 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-017 When ready[i] is 1, stage i SHALL load valid and data from stage i-1 (stage 0 from in_valid/in_data gated by ~flush); otherwise it holds.
REQ-018 Data registers SHALL load only when the source entry is valid; an invalid move updates only the valid bit.
REQ-019 Latency: an entry accepted at edge N with no stalls SHALL appear with out_valid=1 after edge N+DEPTH-1 (DEPTH cycles from in_data sample to out_data).
REQ-020 Throughput: one entry per cycle sustained while out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-022 Order SHALL be preserved; no entry dropped or duplicated except by flush.
REQ-023 flush=1: out_valid forced 0 that cycle, in_ready 0, all valid bits cleared at the next edge; data registers untouched.
REQ-024 Full pipe (all valid) with out_ready=1 and in_valid=1: simultaneous accept and emit, occupancy unchanged.
REQ-025 DEPTH=1: behaves as a single registered stage with the same rules.

Reset
REQ-026 reset=0 SHALL asynchronously clear all valid bits and data registers to 0, independent of clk.
REQ-027 During reset: out_valid=0, out_data=0, in_ready=0, occupancy=0.
REQ-028 Reset deassertion mid-stream SHALL leave the pipe empty; first accept possible on the first edge after release.

Configuration
REQ-029 Macro PIPE_REG_OCC_EN: when defined, occupancy port and a registered counter SHALL exist.
REQ-030 With PIPE_REG_OCC_EN: +1 on input fire only, -1 on output fire only, unchanged on both or neither, 0 after flush edge, never exceeds DEPTH, equals popcount of valid bits.
REQ-031 Without PIPE_REG_OCC_EN: no occupancy port, no counter logic; all other behaviour identical.

Verification
REQ-032 DEPTH=4, out_ready=1, stream 0x0001..0x0008 back-to-back -> out_data 0x0001..0x0008 in order, first at 4 cycles, then one per cycle.
REQ-033 Fill 4 entries with out_ready=0 -> in_ready=0 after 4th accept, occupancy=4, out_data stable at first entry; raise out_ready -> 4 entries drain in 4 cycles.
REQ-034 Full pipe, in_valid=1, out_ready=1, data 0xA5A5 -> accept and emit same cycle, occupancy stays 4.
REQ-035 Three entries in flight, flush pulsed 1 cycle with in_valid=1 -> no output for those entries, flush-cycle input discarded, occupancy=0 next cycle.
REQ-036 Assert reset asynchronously between edges with 2 entries valid -> out_valid=0, out_data=0 immediately; after release, new entry 0x1234 emerges after 4 cycles.
REQ-037 Build without PIPE_REG_OCC_EN and rerun REQ-032 -> identical data and timing, no occupancy port.
